// File: rtl/afl2_seq.sv
// afl2_seq: command sequencer for the afl2_alu datapath.
// Expands one float command per handshake into ALU micro-ops, then pulses done.

`ifndef AFL_INST_BITS
`define AFL_INST_BITS 3
`endif
`ifndef AFL_INST_LOAD
`define AFL_INST_LOAD 0
`endif
`ifndef AFL_INST_CMPABS
`define AFL_INST_CMPABS 1
`endif
`ifndef AFL_INST_ADD
`define AFL_INST_ADD 2
`endif
`ifndef AFL_INST_NORMALIZE
`define AFL_INST_NORMALIZE 3
`endif
`ifndef AFL_INST_SQRT
`define AFL_INST_SQRT 4
`endif

module afl2_seq #(
    parameter int unsigned E_BITS    = 4,
    parameter int unsigned M_BITS    = 8,
    parameter int unsigned INST_BITS = `AFL_INST_BITS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_op,
    input  logic [E_BITS+M_BITS:0]   cmd_operand,
    input  logic                     stall,
    output logic                     done,
    output logic                     cmd_err,
    output logic                     busy,
    output logic                     alu_en,
    output logic [INST_BITS-1:0]     alu_inst,
    output logic [E_BITS+M_BITS:0]   alu_ext,
    output logic                     alu_both_args_same,
    output logic                     alu_both_args_source,
    output logic                     alu_abs_result,
    output logic                     alu_flip_result
);

    localparam int unsigned W = 1 + E_BITS + M_BITS;

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_FADD = 3'd1;
    localparam logic [2:0] OP_FSUB = 3'd2;
    localparam logic [2:0] OP_SQRT = 3'd3;
    localparam logic [2:0] OP_NEG  = 3'd4;
    localparam logic [2:0] OP_ABS  = 3'd5;

    localparam logic [INST_BITS-1:0] INST_LOAD   = INST_BITS'(`AFL_INST_LOAD);
    localparam logic [INST_BITS-1:0] INST_CMPABS = INST_BITS'(`AFL_INST_CMPABS);
    localparam logic [INST_BITS-1:0] INST_ADD    = INST_BITS'(`AFL_INST_ADD);
    localparam logic [INST_BITS-1:0] INST_NORM   = INST_BITS'(`AFL_INST_NORMALIZE);
    localparam logic [INST_BITS-1:0] INST_SQRT   = INST_BITS'(`AFL_INST_SQRT);

    typedef enum logic [2:0] {StIdle, StStep0, StStep1, StStep2, StFin} state_t;

    state_t         r_state;
    logic [2:0]     r_op;
    logic [W-1:0]   r_opnd;
    logic           r_err;

    logic           w_accept;
    logic           w_rsvd;
    logic           w_multi;
    logic           w_in_step;

    assign cmd_ready = ((r_state == StIdle) || (r_state == StFin)) && !stall;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_rsvd    = (cmd_op[2:1] == 2'b11);
    // Only FADD/FSUB run past STEP0.
    assign w_multi   = (r_op == OP_FADD) || (r_op == OP_FSUB);
    assign w_in_step = (r_state == StStep0) || (r_state == StStep1) || (r_state == StStep2);

    assign done    = (r_state == StFin);
    assign cmd_err = (r_state == StFin) && r_err;
    assign busy    = (r_state != StIdle);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_op    <= 3'd0;
            r_opnd  <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                StIdle, StFin: begin
                    if (w_accept) begin
                        r_op    <= cmd_op;
                        r_opnd  <= cmd_operand;
                        r_err   <= w_rsvd;
                        r_state <= w_rsvd ? StFin : StStep0;
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StStep0: if (!stall) r_state <= w_multi ? StStep1 : StFin;
                StStep1: if (!stall) r_state <= StStep2;
                StStep2: if (!stall) r_state <= StFin;
                default: r_state <= StIdle;
            endcase
        end
    end

    always_comb begin
        alu_en               = 1'b0;
        alu_inst             = INST_LOAD;
        alu_ext              = r_opnd;
        alu_both_args_same   = 1'b0;
        alu_both_args_source = 1'b0;
        alu_abs_result       = 1'b0;
        alu_flip_result      = 1'b0;
        if (w_in_step) begin
            // A stalled step keeps its controls but must not fire.
            alu_en = !stall;
            if (r_op == OP_FSUB) begin
                alu_ext = {~r_opnd[W-1], r_opnd[W-2:0]};
            end
            case (r_op)
                OP_LOAD: alu_inst = INST_LOAD;
                OP_FADD, OP_FSUB: begin
                    case (r_state)
                        StStep0: alu_inst = INST_CMPABS;
                        StStep1: alu_inst = INST_ADD;
                        default: alu_inst = INST_NORM;
                    endcase
                end
                OP_SQRT: alu_inst = INST_SQRT;
                OP_NEG: begin
                    alu_inst           = INST_LOAD;
                    alu_both_args_same = 1'b1;
                    alu_flip_result    = 1'b1;
                end
                OP_ABS: begin
                    alu_inst           = INST_LOAD;
                    alu_both_args_same = 1'b1;
                    alu_abs_result     = 1'b1;
                end
                default: alu_inst = INST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_afl2_seq.sv
// Table-driven bench for afl2_seq: one record per clock cycle, plus a
// hand-written latency/issue-count sequence for FADD.

module tb_afl2_seq;

    localparam int W = 13;

    localparam logic [2:0] L = 3'd0;
    localparam logic [2:0] C = 3'd1;
    localparam logic [2:0] A = 3'd2;
    localparam logic [2:0] N = 3'd3;
    localparam logic [2:0] S = 3'd4;

    localparam logic [2:0] LOAD = 3'd0;
    localparam logic [2:0] FADD = 3'd1;
    localparam logic [2:0] FSUB = 3'd2;
    localparam logic [2:0] SQRT = 3'd3;
    localparam logic [2:0] NEG  = 3'd4;
    localparam logic [2:0] ABS  = 3'd5;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [2:0]     cmd_op;
    logic [W-1:0]   cmd_operand;
    logic           stall;
    logic           done;
    logic           cmd_err;
    logic           busy;
    logic           alu_en;
    logic [2:0]     alu_inst;
    logic [W-1:0]   alu_ext;
    logic           alu_both_args_same;
    logic           alu_both_args_source;
    logic           alu_abs_result;
    logic           alu_flip_result;

    afl2_seq #(.E_BITS(4), .M_BITS(8), .INST_BITS(3)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .cmd_valid            (cmd_valid),
        .cmd_ready            (cmd_ready),
        .cmd_op               (cmd_op),
        .cmd_operand          (cmd_operand),
        .stall                (stall),
        .done                 (done),
        .cmd_err              (cmd_err),
        .busy                 (busy),
        .alu_en               (alu_en),
        .alu_inst             (alu_inst),
        .alu_ext              (alu_ext),
        .alu_both_args_same   (alu_both_args_same),
        .alu_both_args_source (alu_both_args_source),
        .alu_abs_result       (alu_abs_result),
        .alu_flip_result      (alu_flip_result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         chk;
        logic         rst_n;
        logic         valid;
        logic [2:0]   op;
        logic [W-1:0] opnd;
        logic         stall;
        logic         rdy;
        logic         done;
        logic         err;
        logic         busy;
        logic         en;
        logic [2:0]   inst;
        logic [W-1:0] ext;
        logic [3:0]   mods;  // {same, source, abs, flip}
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic vec_t mk(logic chk, logic rs, logic va, logic [2:0] op, logic [W-1:0] od,
                                logic st, logic rdy, logic dn, logic er, logic bs, logic en,
                                logic [2:0] inst, logic [W-1:0] ext, logic [3:0] mods);
        vec_t v;
        v.chk = chk; v.rst_n = rs; v.valid = va; v.op = op; v.opnd = od; v.stall = st;
        v.rdy = rdy; v.done = dn; v.err = er; v.busy = bs; v.en = en;
        v.inst = inst; v.ext = ext; v.mods = mods;
        return v;
    endfunction

    task automatic cmp(input int idx, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL vec %0d %s: got 0x%0h, expected 0x%0h", idx, name, act, exp);
        end
    endtask

    task automatic check_vec(input int i);
        vec_t v;
        v = vecs[i];
        n_vec++;
        cmp(i, "cmd_ready", 32'(cmd_ready), 32'(v.rdy));
        cmp(i, "done", 32'(done), 32'(v.done));
        cmp(i, "cmd_err", 32'(cmd_err), 32'(v.err));
        cmp(i, "busy", 32'(busy), 32'(v.busy));
        cmp(i, "alu_en", 32'(alu_en), 32'(v.en));
        cmp(i, "alu_inst", 32'(alu_inst), 32'(v.inst));
        cmp(i, "alu_ext", 32'(alu_ext), 32'(v.ext));
        cmp(i, "mods", 32'({alu_both_args_same, alu_both_args_source, alu_abs_result,
                            alu_flip_result}), 32'(v.mods));
    endtask

    initial begin
        int lat;
        int en_cnt;
        logic got;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_operand = '0; stall = 1'b0;

        // Reset
        vecs.push_back(mk(0,0,0,0,0,0,         0,0,0,0,0,L,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,         0,0,0,0,0,L,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,         1,0,0,0,0,L,0,0));
        // LOAD 0x000
        vecs.push_back(mk(1,1,1,LOAD,0,0,      1,0,0,0,0,L,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,         0,0,0,1,1,L,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,         1,1,0,1,0,L,0,0));
        // FADD 0x000
        vecs.push_back(mk(1,1,1,FADD,0,0,      1,0,0,0,0,L,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,         0,0,0,1,1,C,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,         0,0,0,1,1,A,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,         0,0,0,1,1,N,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,         1,1,0,1,0,L,0,0));
        // FSUB 0x000: sign-flipped ext in every step only
        vecs.push_back(mk(1,1,1,FSUB,0,0,      1,0,0,0,0,L,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,         0,0,0,1,1,C,13'h1000,0));
        vecs.push_back(mk(1,1,0,0,0,0,         0,0,0,1,1,A,13'h1000,0));
        vecs.push_back(mk(1,1,0,0,0,0,         0,0,0,1,1,N,13'h1000,0));
        vecs.push_back(mk(1,1,0,0,0,0,         1,1,0,1,0,L,0,0));
        // FADD with stall T+2..T+4; offered command during stall ignored
        vecs.push_back(mk(1,1,1,FADD,13'h0A5,0, 1,0,0,0,0,L,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,         0,0,0,1,1,C,13'h0A5,0));
        vecs.push_back(mk(1,1,1,SQRT,13'h123,1, 0,0,0,1,0,A,13'h0A5,0));
        vecs.push_back(mk(1,1,1,SQRT,13'h123,1, 0,0,0,1,0,A,13'h0A5,0));
        vecs.push_back(mk(1,1,1,SQRT,13'h123,1, 0,0,0,1,0,A,13'h0A5,0));
        vecs.push_back(mk(1,1,0,0,0,0,         0,0,0,1,1,A,13'h0A5,0));
        vecs.push_back(mk(1,1,0,0,0,0,         0,0,0,1,1,N,13'h0A5,0));
        vecs.push_back(mk(1,1,0,0,0,0,         1,1,0,1,0,L,13'h0A5,0));
        // NEG then ABS back-to-back, second accepted in FIN
        vecs.push_back(mk(1,1,1,NEG,13'h055,0, 1,0,0,0,0,L,13'h0A5,0));
        vecs.push_back(mk(1,1,1,ABS,13'h1AA,0, 0,0,0,1,1,L,13'h055,4'b1001));
        vecs.push_back(mk(1,1,1,ABS,13'h1AA,0, 1,1,0,1,0,L,13'h055,0));
        vecs.push_back(mk(1,1,0,0,0,0,         0,0,0,1,1,L,13'h1AA,4'b1010));
        vecs.push_back(mk(1,1,0,0,0,0,         1,1,0,1,0,L,13'h1AA,0));
        vecs.push_back(mk(1,1,0,0,0,0,         1,0,0,0,0,L,13'h1AA,0));
        // Reserved op 6
        vecs.push_back(mk(1,1,1,3'd6,13'h0F0,0, 1,0,0,0,0,L,13'h1AA,0));
        vecs.push_back(mk(1,1,0,0,0,0,         1,1,1,1,0,L,13'h0F0,0));
        vecs.push_back(mk(1,1,0,0,0,0,         1,0,0,0,0,L,13'h0F0,0));
        // SQRT
        vecs.push_back(mk(1,1,1,SQRT,13'h123,0, 1,0,0,0,0,L,13'h0F0,0));
        vecs.push_back(mk(1,1,0,0,0,0,         0,0,0,1,1,S,13'h123,0));
        vecs.push_back(mk(1,1,0,0,0,0,         1,1,0,1,0,L,13'h123,0));
        // Reserved op 7; FIN under stall still ends, no accept
        vecs.push_back(mk(1,1,1,3'd7,0,0,      1,0,0,0,0,L,13'h123,0));
        vecs.push_back(mk(1,1,1,LOAD,13'h077,1, 0,1,1,1,0,L,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,         1,0,0,0,0,L,0,0));
        // Reset during STEP1 of FADD aborts with no done
        vecs.push_back(mk(1,1,1,FADD,13'h033,0, 1,0,0,0,0,L,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,         0,0,0,1,1,C,13'h033,0));
        vecs.push_back(mk(1,0,0,0,0,0,         0,0,0,1,1,A,13'h033,0));
        vecs.push_back(mk(1,1,0,0,0,0,         1,0,0,0,0,L,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,         1,0,0,0,0,L,0,0));
        // Stall in IDLE blocks acceptance
        vecs.push_back(mk(1,1,1,LOAD,13'h077,1, 0,0,0,0,0,L,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,         1,0,0,0,0,L,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_n       = vecs[i].rst_n;
            cmd_valid   = vecs[i].valid;
            cmd_op      = vecs[i].op;
            cmd_operand = vecs[i].opnd;
            stall       = vecs[i].stall;
            #1;
            if (vecs[i].chk) check_vec(i);
        end

        // FADD issued exactly three times, done in T+4
        @(negedge clk);
        rst_n = 1'b1; stall = 1'b0;
        cmd_valid = 1'b1; cmd_op = FADD; cmd_operand = 13'h011;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 0; en_cnt = 0; got = 1'b0;
        for (int k = 1; k <= 20 && !got; k++) begin
            #1;
            if (alu_en) en_cnt++;
            if (done) begin
                got = 1'b1;
                lat = k;
            end
            @(negedge clk);
        end
        n_vec++;
        cmp(-1, "fadd_done_seen", 32'(got), 32'd1);
        n_vec++;
        cmp(-1, "fadd_done_latency", 32'(lat), 32'd4);
        n_vec++;
        cmp(-1, "fadd_en_pulses", 32'(en_cnt), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
